// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, default width, request payload
// and the response-buffer state encoding used by alu_share_arbiter.
package alu_pkg;

  localparam int unsigned WIDTH = 8;

  // Encoding 2'h3 is unused and behaves like OP_MUX (pass operand A).
  typedef enum logic [1:0] {
    OP_ADD = 2'h0,
    OP_SUB = 2'h1,
    OP_MUX = 2'h2
  } operation_e;

  typedef struct packed {
    operation_e       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } alu_req_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: ADD / SUB / pass-through, unsigned, modulo 2^DATA_WIDTH.
// Ports:
//   op       - operation select
//   a, b     - operands
//   result_c - combinational result
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WIDTH
) (
  input  operation_e            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result_c
);

  // Carry and borrow are dropped by the fixed-width assignment.
  always_comb begin
    result_c = a;
    case (op)
      OP_ADD:  result_c = a + b;
      OP_SUB:  result_c = a - b;
      default: result_c = a;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration and
// a single-entry registered response buffer.
// Ports:
//   clk_i, rst_ni              - clock, async active-low reset
//   req_valid_i / req_ready_o  - per-requester handshake (ready one-hot or zero)
//   req_op_i, req_a_i, req_b_i - per-requester operation and operands
//   rsp_valid_o / rsp_ready_i  - response handshake
//   rsp_id_o, rsp_data_o       - winning requester index and result
//   busy_o                     - response pending or any request valid
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = WIDTH,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  operation_e [NUM_REQ-1:0]            req_op_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [ID_W-1:0]                     rsp_id_o,
  output logic [DATA_WIDTH-1:0]               rsp_data_o,
  output logic                                busy_o
);

  buf_state_e            state_q, state_d;
  logic [ID_W-1:0]       rr_q, rr_next;
  logic [ID_W-1:0]       grant_idx;
  logic                  grant_found;
  logic                  can_accept;
  logic                  grant;
  logic [ID_W-1:0]       rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [DATA_WIDTH-1:0] alu_result;

  // Round-robin search: first valid index at or after rr_q, wrapping.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid_i[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // A grant needs a free buffer slot, or one being drained this cycle.
  // Ready is also forced low while reset is asserted.
  assign can_accept  = !rsp_valid_o || rsp_ready_i;
  assign grant       = grant_found && can_accept && rst_ni;
  assign req_ready_o = grant ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rr_next     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  alu_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu_core (
    .op       (req_op_i[grant_idx]),
    .a        (req_a_i[grant_idx]),
    .b        (req_b_i[grant_idx]),
    .result_c (alu_result)
  );

  // Response buffer state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= BUF_EMPTY;
    else         state_q <= state_d;
  end

  // Response buffer next state; a grant while FULL replaces the entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (grant)                 state_d = BUF_FULL;
      BUF_FULL:  if (rsp_ready_i && !grant) state_d = BUF_EMPTY;
      default:                              state_d = BUF_EMPTY;
    endcase
  end

  // Pointer and response payload only move on a grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else if (grant) begin
      rr_q       <= rr_next;
      rsp_id_q   <= grant_idx;
      rsp_data_q <= alu_result;
    end
  end

  assign rsp_valid_o = (state_q == BUF_FULL);
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = rsp_valid_o || (|req_valid_i);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus a randomized run,
// all checked against a behavioural model of the arbiter and response buffer.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [3:0]           req_valid;
  logic [3:0]           req_ready;
  operation_e [3:0]     req_op;
  logic [3:0][7:0]      req_a;
  logic [3:0][7:0]      req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [7:0]           rsp_data;
  logic                 busy;

  int tests = 0;
  int fails = 0;

  // Model state: buffer occupancy, held result, priority pointer.
  bit m_full;
  int m_id;
  int m_data;
  int m_rr;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy)
  );

  function automatic int alu_ref(input int op, input int a, input int b);
    case (op)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      default: return a;
    endcase
  endfunction

  // Which requester the model expects to win this cycle, -1 for none.
  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_full && !rsp_ready) return -1;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (m_rr + i) % 4;
      if (req_valid[2'(k)]) return k;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int g);
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_id   = 0;
    m_data = 0;
    m_rr   = 0;
  endtask

  // Advance one clock edge and update the model with what was presented.
  task automatic tick();
    int g;
    g = model_grant();
    @(posedge clk);
    if (g >= 0) begin
      m_full = 1'b1;
      m_id   = g;
      m_data = alu_ref(int'(req_op[2'(g)]), int'(req_a[2'(g)]), int'(req_b[2'(g)]));
      m_rr   = (g + 1) % 4;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic randomize_lane(input int k);
    req_op[2'(k)] = operation_e'(2'($urandom_range(0, 3)));
    req_a[2'(k)]  = 8'($urandom_range(0, 255));
    req_b[2'(k)]  = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) randomize_lane(k);
    model_reset();
    @(negedge clk);
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_id: got %0d expected 0", rsp_id); end
    tests++; if (rsp_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", rsp_data); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", busy); end
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_add();
    req_valid = 4'b0100;
    req_op[2] = OP_ADD;
    req_a[2]  = 8'h05;
    req_b[2]  = 8'h03;
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL add_ready: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL add_valid: got %b expected 1", rsp_valid); end
    tests++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL add_id: got %0d expected 2", rsp_id); end
    tests++; if (rsp_data !== 8'h08) begin fails++; $display("FAIL add_data: got %h expected 08", rsp_data); end
  endtask

  task automatic test_sub_mux();
    operation_e  ops [3];
    logic [7:0]  ta  [3];
    logic [7:0]  tb_ [3];
    logic [7:0]  exp [3];
    ops = '{OP_SUB, OP_MUX, operation_e'(2'h3)};
    ta  = '{8'h02, 8'hA5, 8'h11};
    tb_ = '{8'h05, 8'h3C, 8'h77};
    exp = '{8'hFD, 8'hA5, 8'h11};
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b0001;
      req_op[0] = ops[i];
      req_a[0]  = ta[i];
      req_b[0]  = tb_[i];
      tick();
      tests++; if (rsp_data !== exp[i]) begin fails++; $display("FAIL op_data[%0d]: got %h expected %h", i, rsp_data, exp[i]); end
      tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL op_id[%0d]: got %0d expected 0", i, rsp_id); end
    end
    req_valid = '0;
  endtask

  task automatic test_overflow();
    req_valid = 4'b0010;
    req_op[1] = OP_ADD;
    req_a[1]  = 8'hFF;
    req_b[1]  = 8'h01;
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid: got %b expected 1", rsp_valid); end
    tests++; if (rsp_data !== 8'h00) begin fails++; $display("FAIL ovf_data: got %h expected 00", rsp_data); end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int k = 0; k < 4; k++) randomize_lane(k);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++; if (req_ready !== 4'(1 << (i % 4))) begin fails++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, req_ready, 4'(1 << (i % 4))); end
      tick();
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rr_valid[%0d]: got %b expected 1", i, rsp_valid); end
      tests++; if (rsp_id !== 2'(i % 4)) begin fails++; $display("FAIL rr_id[%0d]: got %0d expected %0d", i, rsp_id, i % 4); end
      tests++; if (rsp_data !== 8'(m_data)) begin fails++; $display("FAIL rr_data[%0d]: got %h expected %h", i, rsp_data, 8'(m_data)); end
      randomize_lane(i % 4);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0010;
    req_op[1] = OP_ADD;
    req_a[1]  = 8'h20;
    req_b[1]  = 8'h0A;
    rsp_ready = 1'b1;
    tick();
    tests++; if (rsp_data !== 8'h2A || rsp_id !== 2'd1) begin fails++; $display("FAIL bp_fill: got id %0d data %h expected id 1 data 2a", rsp_id, rsp_data); end
    randomize_lane(0);
    randomize_lane(3);
    req_valid = 4'b1001;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, req_ready); end
      tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h2A) begin fails++; $display("FAIL bp_hold[%0d]: got v%b id %0d data %h expected v1 id 1 data 2a", i, rsp_valid, rsp_id, rsp_data); end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL bp_release_ready: got %b expected 1000", req_ready); end
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin fails++; $display("FAIL bp_release_rsp: got v%b id %0d expected v1 id 3", rsp_valid, rsp_id); end
    tests++; if (rsp_data !== 8'(m_data)) begin fails++; $display("FAIL bp_release_data: got %h expected %h", rsp_data, 8'(m_data)); end
  endtask

  task automatic test_reset_midflight();
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid: got %b expected 1", rsp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b expected 0", rsp_valid); end
    tests++; if (rsp_data !== 8'h00 || rsp_id !== 2'd0) begin fails++; $display("FAIL mid_payload: got id %0d data %h expected id 0 data 00", rsp_id, rsp_data); end
    randomize_lane(0);
    randomize_lane(1);
    req_valid = 4'b0011;
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_ready_in_reset: got %b expected 0000", req_ready); end
    rst_n = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    tests++; if (rsp_id !== 2'd0 || rsp_data !== 8'(m_data)) begin fails++; $display("FAIL mid_rsp: got id %0d data %h expected id 0 data %h", rsp_id, rsp_data, 8'(m_data)); end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_valid[2'(k)] = 1'($urandom_range(0, 1));
      randomize_lane(k);
    end
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = model_grant();
      tests++; if (req_ready !== exp_ready(g)) begin fails++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, req_ready, exp_ready(g)); end
      tests++; if (rsp_valid !== m_full) begin fails++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, rsp_valid, m_full); end
      tests++; if (rsp_id !== 2'(m_id) || rsp_data !== 8'(m_data)) begin fails++; $display("FAIL rnd_rsp[%0d]: got id %0d data %h expected id %0d data %h", i, rsp_id, rsp_data, m_id, 8'(m_data)); end
      tests++; if (busy !== (m_full || (|req_valid))) begin fails++; $display("FAIL rnd_busy[%0d]: got %b expected %b", i, busy, m_full || (|req_valid)); end
      tick();
      for (int k = 0; k < 4; k++) begin
        if (g == k || !req_valid[2'(k)]) begin
          req_valid[2'(k)] = ($urandom_range(0, 2) != 0);
          randomize_lane(k);
        end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_op    = '{default: OP_ADD};
    req_a     = '0;
    req_b     = '0;
    model_reset();
    test_reset();
    test_single_add();
    test_sub_mux();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
